kypd_scanner: RTL and testbench
===============================

Name: kypd_scanner

Overview:
- Scans a 4x4 matrix keypad (Pmod KYPD layout) by driving columns low one at a time and sampling the rows.
- Debounces the result and presents a 4-bit key code plus press/valid strobes.
- Upstream producer of the key_value input consumed by keypad_decoder (key code to clock-divider factor).
- Sits between the keypad pins and the tone path.

Parameters:
- SCAN_DIV, 100000: settle cycles each column is driven before rows are sampled (1 ms at 100 MHz); must be >= 3.
- DEBOUNCE_CNT, 20: consecutive identical scan frames required before a press or release is accepted; must be >= 2.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- row_i  in  4  keypad rows, active-low (pulled up externally), asynchronous to clk_i.
- col_o  out  4  keypad column drive, active-low one-hot.
- key_value_o  out  4  debounced key code; 4'h0 when no key is held.
- key_pressed_o  out  1  high while a debounced key is held.
- key_valid_o  out  1  one-cycle pulse when key_value_o changes to a new pressed key.

Behaviour:
- Reset: synchronous and active-low; rst_ni sampled low at a clock edge forces the reset values on that edge. It applies mid-scan or mid-debounce with no residual state. Reset values:
  - col_o=4'b1110.
  - key_value_o=4'h0, key_pressed_o=0, key_valid_o=0.
  - Column index 0, settle count 0, stable count 0.
  - Previous frame code = "none".
  - FSM in SETTLE.
- Synchroniser: row_i passes through a 2-flop synchroniser before use. A row must therefore be stable at least 2 cycles before the SAMPLE cycle.
- FSM states:
  - SETTLE: count SCAN_DIV cycles with col_o driving the current column.
  - SAMPLE: one cycle. Latch the synchronised rows for this column. If column < 3, increment column and go to SETTLE; col_o changes on the clock edge leaving SAMPLE. If column = 3, go to EVAL.
  - EVAL: one cycle. Compute the frame code, update debounce, set column to 0 and col_o to 4'b1110, go to SETTLE.
- Timing: column period = SCAN_DIV+1 cycles; frame period = 4*(SCAN_DIV+1)+1 cycles.
- Key map (row r, column c → code):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0, F, E, D
- Frame code:
  - Lowest column wins, then lowest row, among the low row bits latched across the frame.
  - If no row bit is low, the code is "none", held internally as a 5th state distinct from key 0.
- Debounce (in EVAL):
  - Frame code equal to previous frame code: stable count increments, saturating at DEBOUNCE_CNT-1.
  - Frame code different: stable count resets to 0.
  - Previous frame code is updated every frame.
  - Accept: when stable count reaches DEBOUNCE_CNT-1 on this EVAL (DEBOUNCE_CNT identical frames) and the frame code differs from the current debounced state, act on the next edge as follows.
- Accepted press (new code K, including K=0):
  - key_value_o=K, key_pressed_o=1, key_valid_o=1 for exactly one cycle.
  - Press to a different key with no intervening release (e.g. 5 held → 8 held) is a new press: key_value_o updates and valid pulses again.
- Accepted release ("none"): key_value_o=4'h0, key_pressed_o=0, no valid pulse.
- Holds and saturation:
  - A held key produces no repeated valid pulses.
  - The saturated counter does not re-trigger.
- Key 0 versus idle: key 0 and idle both give key_value_o=0; key_pressed_o distinguishes them.
- Bounce: any mismatched frame restarts the count, so the outputs never change before DEBOUNCE_CNT identical frames.
- Multi-key: priority encoding above; releasing the priority key while another stays held is a code change and is debounced as a new press.

Test Plan:
- Frame timing (all scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3): after reset, rows idle → col_o sequence 1110, 1101, 1011, 0111, each held 5 cycles; EVAL then returns to 1110; frame = 21 cycles; outputs stay 0/0/0.
- Press and release of key 5: hold row1 low while column 1 is driven, for 3 full frames → at the 3rd EVAL+1 edge, key_value_o=4'h5, key_pressed_o=1, key_valid_o high exactly 1 cycle. Release for 3 frames → key_value_o=0, key_pressed_o=0, no valid pulse.
- Bounce rejection: alternate key C (row2/column 3) pressed and released on successive frames for 10 frames → no output change; then hold 3 frames → key_value_o=4'hC, one valid pulse.
- Key 0 versus idle, and multi-key: press key 0 (row3/column 0) → key_value_o=0, key_pressed_o=1, one valid pulse. Hold keys 9 and A together → key_value_o=4'h9 (column 2 beats column 3). Release 9 while A is held → after 3 frames key_value_o=4'hA, new valid pulse.
- Reset mid-operation: with key 7 accepted and mid-frame, drive rst_ni low for 1 cycle → on that edge col_o=1110 and all outputs 0. Key 7 still held → re-accepted 3 frames later with one valid pulse.

Source files
------------

// File: rtl/kypd_scanner.sv
// -----------------------------------------------------------------------------
// kypd_scanner
//
// Purpose:
//   Scans a 4x4 matrix keypad (Pmod KYPD layout). The scanner drives one column
//   low at a time and samples the rows. A full frame of row samples becomes a
//   single key code. That code is debounced over a number of identical frames
//   and then presented as a 4-bit key value with press and valid strobes. The
//   key value feeds the keypad decoder on the tone path.
//
//   Scan sequence (one frame = 4*(SCAN_DIV+1)+1 cycles):
//     SETTLE (SCAN_DIV cycles) -> SAMPLE (1 cycle)   repeated for columns 0..3
//     EVAL   (1 cycle) after column 3, then back to column 0.
//
//   Key map (row r, column c):
//     r0: 1 2 3 A
//     r1: 4 5 6 B
//     r2: 7 8 9 C
//     r3: 0 F E D
//   Among all low row bits of a frame, the lowest column wins, then the lowest
//   row. A frame with no low row bit yields the internal code "none". This
//   code is a fifth value, kept separate from key 0.
//
// Parameters:
//   SCAN_DIV      settle cycles per column before sampling (>= 3)
//   DEBOUNCE_CNT  identical frames needed to accept a press/release (>= 2)
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         synchronous active-low reset
//   row_i[3:0]     keypad rows, active-low, asynchronous to clk_i
//   col_o[3:0]     column drive, active-low one-hot
//   key_value_o    debounced key code, 4'h0 when no key is held
//   key_pressed_o  high while a debounced key is held
//   key_valid_o    one-cycle pulse when a new pressed key is accepted
// -----------------------------------------------------------------------------
module kypd_scanner #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_value_o,
  output logic       key_pressed_o,
  output logic       key_valid_o
);

  localparam int SET_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STABLE_MAX  = STB_W'(DEBOUNCE_CNT - 1);

  // Bit 4 set marks "no key in this frame"; the low nibble is then don't-care.
  localparam logic [4:0] CODE_NONE = 5'h10;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_EVAL   = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       col_idx;
  logic [SET_W-1:0] settle_cnt;
  logic [STB_W-1:0] stable_cnt;
  logic [4:0]       prev_code;
  logic [4:0]       deb_code;
  logic [3:0][3:0]  row_lat;     // row_lat[column][row], active-low

  logic [3:0]       row_p0;
  logic [3:0]       row_p1;

  logic [4:0]       code_now;
  logic [STB_W-1:0] stable_nxt;
  logic             accept;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Physical keypad position to key code.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'h0;
      4'b11_01: k = 4'hF;
      4'b11_10: k = 4'hE;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Priority encode a frame. The scan walks from the highest position down,
  // so the last hit written is the lowest column, then the lowest row.
  function automatic logic [4:0] frame_code(input logic [3:0][3:0] rows);
    logic [4:0] code;
    code = CODE_NONE;
    for (int c = 3; c >= 0; c--) begin
      for (int r = 3; r >= 0; r--) begin
        if (!rows[c][r]) begin
          code = {1'b0, key_map(2'(r), 2'(c))};
        end
      end
    end
    return code;
  endfunction

  // Stable-frame counter increment that holds at DEBOUNCE_CNT-1. Holding
  // there prevents a long hold from wrapping around and re-triggering.
  function automatic logic [STB_W-1:0] sat_inc(input logic [STB_W-1:0] cnt);
    return (cnt == STABLE_MAX) ? cnt : cnt + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0/p1: two-flop synchroniser for the asynchronous row inputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    row_p0 <= row_i;
    row_p1 <= row_p0;
  end

  // ---------------------------------------------------------------------------
  // Frame evaluation (used only in EVAL)
  // ---------------------------------------------------------------------------
  always_comb begin
    code_now   = frame_code(row_lat);
    stable_nxt = (code_now == prev_code) ? sat_inc(stable_cnt) : '0;
    // Accept only when enough identical frames have been seen and the code
    // actually moves the debounced state. A saturated hold therefore stays
    // silent.
    accept     = (stable_nxt == STABLE_MAX) && (code_now != deb_code);
  end

  // ---------------------------------------------------------------------------
  // Scan / debounce FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= ST_SETTLE;
      col_idx       <= 2'd0;
      col_o         <= 4'b1110;
      settle_cnt    <= '0;
      stable_cnt    <= '0;
      prev_code     <= CODE_NONE;
      deb_code      <= CODE_NONE;
      row_lat       <= '1;
      key_value_o   <= 4'h0;
      key_pressed_o <= 1'b0;
      key_valid_o   <= 1'b0;
    end else begin
      key_valid_o <= 1'b0;
      case (state)
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        ST_SAMPLE: begin
          row_lat[col_idx] <= row_p1;
          if (col_idx == 2'd3) begin
            // Column 3 stays driven through EVAL. The wrap to column 0
            // happens on the edge leaving EVAL.
            state <= ST_EVAL;
          end else begin
            col_idx <= col_idx + 2'd1;
            col_o   <= col_drive(col_idx + 2'd1);
            state   <= ST_SETTLE;
          end
        end

        ST_EVAL: begin
          prev_code  <= code_now;
          stable_cnt <= stable_nxt;
          if (accept) begin
            deb_code <= code_now;
            if (code_now[4]) begin
              key_value_o   <= 4'h0;
              key_pressed_o <= 1'b0;
            end else begin
              key_value_o   <= code_now[3:0];
              key_pressed_o <= 1'b1;
              key_valid_o   <= 1'b1;
            end
          end
          col_idx <= 2'd0;
          col_o   <= 4'b1110;
          state   <= ST_SETTLE;
        end

        default: begin
          state <= ST_SETTLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kypd_scanner.sv
// -----------------------------------------------------------------------------
// tb_kypd_scanner
//
// Testbench for kypd_scanner with SCAN_DIV=4 and DEBOUNCE_CNT=3.
//
// The bench contains an ideal keypad. It holds a set of pressed keys and
// pulls a row low whenever a driven column crosses a pressed key. Stimulus
// changes only at frame boundaries.
//
// A frame-level reference model tracks the expected outputs. Each frame it
// works out the frame's key from the pressed set and appends it to a history
// of frame codes. A key change is accepted when the last DEBOUNCE_CNT history
// entries agree and differ from the debounced key. Right after reset the
// history holds one "none" entry.
// -----------------------------------------------------------------------------
module tb_kypd_scanner;

  localparam int SD    = 4;
  localparam int DB    = 3;
  localparam int FRAME = 4 * (SD + 1) + 1;
  localparam int NONE  = 16;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_value_o;
  logic       key_pressed_o;
  logic       key_valid_o;

  logic [15:0] keys_held = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // km[row][col] = key code
  int km [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  // Reference model state
  int         hist[$];
  int         m_deb;
  logic [3:0] m_val;
  logic       m_pr;
  logic       m_vld;

  // Observations from the most recent frame, and the expectations for it
  logic [3:0] f_col [FRAME];
  logic [3:0] f_val0;
  logic       f_pr0;
  logic       f_vld_p0;
  int         f_vld_cnt;
  logic       f_chg;
  logic [3:0] e_val;
  logic       e_pr;
  logic       e_vld;

  always #5 clk = ~clk;

  kypd_scanner #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DB)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .row_i         (row_i),
    .col_o         (col_o),
    .key_value_o   (key_value_o),
    .key_pressed_o (key_pressed_o),
    .key_valid_o   (key_valid_o)
  );

  // Ideal keypad: a row reads low when any pressed key on it sits in a
  // column that is currently driven low.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (col_o[c] === 1'b0 && keys_held[km[r][c]]) row_i[r] = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic int ref_code(input logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[km[r][c]]) return km[r][c];
    return NONE;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(NONE);
    m_deb = NONE;
    m_val = 4'h0;
    m_pr  = 1'b0;
    m_vld = 1'b0;
  endtask

  // Run one scan frame with the key set k applied from its first cycle.
  // Records what the DUT did and advances the model. The caller compares.
  task automatic frame(input logic [15:0] k);
    int code;
    bit same;
    e_val     = m_val;
    e_pr      = m_pr;
    e_vld     = m_vld;
    f_vld_cnt = 0;
    f_chg     = 1'b0;
    for (int p = 0; p < FRAME; p++) begin
      @(negedge clk);
      if (p == 0) begin
        f_val0    = key_value_o;
        f_pr0     = key_pressed_o;
        f_vld_p0  = key_valid_o;
        keys_held = k;
      end else if (key_value_o !== f_val0 || key_pressed_o !== f_pr0) begin
        f_chg = 1'b1;
      end
      f_col[p] = col_o;
      if (key_valid_o !== 1'b0) f_vld_cnt++;
    end
    @(posedge clk);
    code = ref_code(k);
    hist.push_back(code);
    same = (hist.size() >= DB);
    for (int i = 0; i < DB && i < hist.size(); i++)
      if (hist[hist.size() - 1 - i] != code) same = 1'b0;
    m_vld = 1'b0;
    if (same && code != m_deb) begin
      m_deb = code;
      if (code == NONE) begin
        m_val = 4'h0;
        m_pr  = 1'b0;
      end else begin
        m_val = 4'(code);
        m_pr  = 1'b1;
        m_vld = 1'b1;
      end
    end
    if (hist.size() > 32) void'(hist.pop_front());
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    keys_held = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (col_o !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_col: got %b, expected 1110", col_o);
    end
    n_checks++;
    if (key_value_o !== 4'h0 || key_pressed_o !== 1'b0 || key_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got value=%h pressed=%b valid=%b, expected 0/0/0",
               key_value_o, key_pressed_o, key_valid_o);
    end
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_frame_timing();
    logic [3:0] exp_col;
    int c;
    for (int f = 0; f < 2; f++) begin
      frame('0);
      for (int p = 0; p < FRAME; p++) begin
        c = p / (SD + 1);
        if (c > 3) c = 3;
        exp_col = 4'hF ^ (4'b0001 << c);
        n_checks++;
        if (f_col[p] !== exp_col) begin
          n_fail++;
          $display("FAIL timing_col frame %0d cycle %0d: got %b, expected %b", f, p, f_col[p], exp_col);
        end
      end
      n_checks++;
      if (f_val0 !== 4'h0 || f_pr0 !== 1'b0 || f_vld_cnt != 0 || f_chg) begin
        n_fail++;
        $display("FAIL timing_idle_out frame %0d: got value=%h pressed=%b pulses=%0d chg=%b, expected 0/0/0/0",
                 f, f_val0, f_pr0, f_vld_cnt, f_chg);
      end
    end
  endtask

  task automatic test_press_release();
    logic [15:0] seq [7] = '{16'h0020, 16'h0020, 16'h0020, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < 7; i++) begin
      frame(seq[i]);
      n_checks++;
      if (f_val0 !== e_val || f_pr0 !== e_pr || f_chg) begin
        n_fail++;
        $display("FAIL press5_out frame %0d: got value=%h pressed=%b chg=%b, expected value=%h pressed=%b chg=0",
                 i, f_val0, f_pr0, f_chg, e_val, e_pr);
      end
      n_checks++;
      if (f_vld_cnt != (e_vld ? 1 : 0) || f_vld_p0 !== e_vld) begin
        n_fail++;
        $display("FAIL press5_valid frame %0d: got pulses=%0d first=%b, expected pulses=%0d",
                 i, f_vld_cnt, f_vld_p0, e_vld ? 1 : 0);
      end
      if (i == 3) begin
        n_checks++;
        if (f_val0 !== 4'h5 || f_pr0 !== 1'b1 || f_vld_cnt != 1) begin
          n_fail++;
          $display("FAIL press5_accept: got value=%h pressed=%b pulses=%0d, expected 5/1/1",
                   f_val0, f_pr0, f_vld_cnt);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (f_val0 !== 4'h0 || f_pr0 !== 1'b0 || f_vld_cnt != 0) begin
          n_fail++;
          $display("FAIL release5: got value=%h pressed=%b pulses=%0d, expected 0/0/0",
                   f_val0, f_pr0, f_vld_cnt);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [15:0] kc;
    kc = 16'h1000;
    for (int i = 0; i < 14; i++) begin
      frame((i >= 10) ? kc : ((i % 2 == 0) ? kc : 16'h0));
      n_checks++;
      if (f_val0 !== e_val || f_pr0 !== e_pr || f_chg ||
          f_vld_cnt != (e_vld ? 1 : 0) || f_vld_p0 !== e_vld) begin
        n_fail++;
        $display("FAIL bounce frame %0d: got value=%h pressed=%b pulses=%0d chg=%b, expected value=%h pressed=%b pulses=%0d",
                 i, f_val0, f_pr0, f_vld_cnt, f_chg, e_val, e_pr, e_vld ? 1 : 0);
      end
      if (i < 11) begin
        n_checks++;
        if (f_val0 !== 4'h0 || f_pr0 !== 1'b0 || f_vld_cnt != 0) begin
          n_fail++;
          $display("FAIL bounce_hold frame %0d: got value=%h pressed=%b pulses=%0d, expected 0/0/0",
                   i, f_val0, f_pr0, f_vld_cnt);
        end
      end
    end
    n_checks++;
    if (f_val0 !== 4'hC || f_pr0 !== 1'b1 || f_vld_cnt != 1) begin
      n_fail++;
      $display("FAIL bounce_accept: got value=%h pressed=%b pulses=%0d, expected C/1/1",
               f_val0, f_pr0, f_vld_cnt);
    end
  endtask

  task automatic test_key0_multi();
    logic [15:0] masks [3] = '{16'h0001, 16'h0600, 16'h0400};
    logic [3:0]  want  [3] = '{4'h0, 4'h9, 4'hA};
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 4; i++) begin
        frame(masks[s]);
        n_checks++;
        if (f_val0 !== e_val || f_pr0 !== e_pr || f_chg ||
            f_vld_cnt != (e_vld ? 1 : 0) || f_vld_p0 !== e_vld) begin
          n_fail++;
          $display("FAIL multi step %0d frame %0d: got value=%h pressed=%b pulses=%0d chg=%b, expected value=%h pressed=%b pulses=%0d",
                   s, i, f_val0, f_pr0, f_vld_cnt, f_chg, e_val, e_pr, e_vld ? 1 : 0);
        end
      end
      n_checks++;
      if (f_val0 !== want[s] || f_pr0 !== 1'b1 || f_vld_cnt != 1) begin
        n_fail++;
        $display("FAIL multi_accept step %0d: got value=%h pressed=%b pulses=%0d, expected %h/1/1",
                 s, f_val0, f_pr0, f_vld_cnt, want[s]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 4; i++) frame(16'h0080);
    n_checks++;
    if (f_val0 !== 4'h7 || f_pr0 !== 1'b1 || f_vld_cnt != 1) begin
      n_fail++;
      $display("FAIL key7_accept: got value=%h pressed=%b pulses=%0d, expected 7/1/1",
               f_val0, f_pr0, f_vld_cnt);
    end
    n = $urandom_range(6, 18);
    repeat (n) @(negedge clk);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (col_o !== 4'b1110 || key_value_o !== 4'h0 || key_pressed_o !== 1'b0 || key_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid (cycle %0d): got col=%b value=%h pressed=%b valid=%b, expected 1110/0/0/0",
               n, col_o, key_value_o, key_pressed_o, key_valid_o);
    end
    rst_ni = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      frame(16'h0080);
      n_checks++;
      if (f_val0 !== e_val || f_pr0 !== e_pr || f_chg ||
          f_vld_cnt != (e_vld ? 1 : 0) || f_vld_p0 !== e_vld) begin
        n_fail++;
        $display("FAIL reaccept7 frame %0d: got value=%h pressed=%b pulses=%0d chg=%b, expected value=%h pressed=%b pulses=%0d",
                 i, f_val0, f_pr0, f_vld_cnt, f_chg, e_val, e_pr, e_vld ? 1 : 0);
      end
    end
    n_checks++;
    if (f_val0 !== 4'h7 || f_pr0 !== 1'b1 || f_vld_cnt != 1) begin
      n_fail++;
      $display("FAIL reaccept7: got value=%h pressed=%b pulses=%0d, expected 7/1/1",
               f_val0, f_pr0, f_vld_cnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] k;
    int hold;
    int nk;
    for (int it = 0; it < 25; it++) begin
      k  = '0;
      nk = $urandom_range(0, 2);
      for (int j = 0; j < nk; j++) k[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        frame(k);
        n_checks++;
        if (f_val0 !== e_val || f_pr0 !== e_pr || f_chg ||
            f_vld_cnt != (e_vld ? 1 : 0) || f_vld_p0 !== e_vld) begin
          n_fail++;
          $display("FAIL random it %0d keys %h: got value=%h pressed=%b pulses=%0d chg=%b, expected value=%h pressed=%b pulses=%0d",
                   it, k, f_val0, f_pr0, f_vld_cnt, f_chg, e_val, e_pr, e_vld ? 1 : 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_press_release();
    test_bounce();
    test_key0_multi();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
